high_score_tracker: RTL

Tracks the best score achieved across games and announces a new record at game end. Sits downstream of the score counter and the game FSM: it consumes the live score and the game-in-progress level. It produces a persistent high score for display, plus a timed celebration/blink signal that the display stage uses to flash the score digits.

---
 rtl/high_score_tracker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/high_score_tracker.sv
// Keeps the best completed-game score, counts games, and drives a timed
// celebration with a blink square wave whenever a new record is set.
module high_score_tracker #(
   parameter int MAX_SCORE    = 9999,
   parameter int CLKS_PER_MS  = 50000,
   parameter int BLINK_MS     = 250,
   parameter int CELEBRATE_MS = 3000,
   localparam int W = $clog2(MAX_SCORE)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         game_in_progress,
   input  logic [W-1:0] score,
   input  logic         clear_high,
   output logic [W-1:0] high_score,
   output logic         new_record,
   output logic         celebrate,
   output logic         blink,
   output logic [7:0]   games_played
);

   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam int MW = $clog2(CELEBRATE_MS + 1);
   localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAYING   = 2'd1,
      COMPARE   = 2'd2,
      CELEBRATE = 2'd3
   } state_t;

   state_t         state_r, state_next_s;
   logic           gip_q_r;
   logic [W-1:0]   score_l_r;
   logic [W-1:0]   high_score_r;
   logic           new_record_r;
   logic           celebrate_r;
   logic           blink_r;
   logic [7:0]     games_played_r;
   logic [PW-1:0]  pre_r;
   logic [MW-1:0]  ms_r;
   logic [BW-1:0]  blink_cnt_r;

   logic           rise_s, fall_s;
   logic [W-1:0]   score_c_s;
   logic           pre_wrap_s, ms_done_s, blink_wrap_s;
   logic           in_cel_s, cel_entry_s;
   logic           capture_s, load_high_s, clr_high_s, count_game_s;

   assign rise_s       = game_in_progress & ~gip_q_r;
   assign fall_s       = ~game_in_progress & gip_q_r;
   assign score_c_s    = (score > W'(MAX_SCORE)) ? W'(MAX_SCORE) : score;
   assign pre_wrap_s   = (pre_r == PW'(CLKS_PER_MS - 1));
   assign ms_done_s    = pre_wrap_s && (ms_r == MW'(CELEBRATE_MS - 1));
   assign blink_wrap_s = pre_wrap_s && (blink_cnt_r == BW'(BLINK_MS - 1));
   assign in_cel_s     = (state_next_s == CELEBRATE);
   assign cel_entry_s  = in_cel_s && (state_r != CELEBRATE);

   // State register and game_in_progress history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         gip_q_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         gip_q_r <= game_in_progress;
      end
   end

   // Next-state decode and datapath strobes
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      load_high_s  = 1'b0;
      clr_high_s   = 1'b0;
      count_game_s = 1'b0;
      case (state_r)
         IDLE: begin
            clr_high_s = clear_high;
            if (rise_s) state_next_s = PLAYING;
            else        state_next_s = IDLE;
         end
         PLAYING: begin
            capture_s = fall_s;
            if (fall_s) state_next_s = COMPARE;
            else        state_next_s = PLAYING;
         end
         COMPARE: begin
            count_game_s = 1'b1;
            if (score_l_r > high_score_r) begin
               load_high_s  = 1'b1;
               state_next_s = CELEBRATE;
            end else begin
               state_next_s = IDLE;
            end
         end
         CELEBRATE: begin
            // A new game wins over clear for the next state, but the clear still acts.
            clr_high_s = clear_high;
            if (rise_s)          state_next_s = PLAYING;
            else if (clear_high) state_next_s = IDLE;
            else if (ms_done_s)  state_next_s = IDLE;
            else                 state_next_s = CELEBRATE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Score latch, high score, record pulse and game counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_l_r      <= {W{1'b0}};
         high_score_r   <= {W{1'b0}};
         new_record_r   <= 1'b0;
         games_played_r <= 8'd0;
      end else begin
         if (capture_s) score_l_r <= score_c_s;
         if (load_high_s)     high_score_r <= score_l_r;
         else if (clr_high_s) high_score_r <= {W{1'b0}};
         new_record_r <= load_high_s;
         if (count_game_s && (games_played_r != 8'd255))
            games_played_r <= games_played_r + 8'd1;
      end
   end

   // Celebration timebase and blink generator; all zeroed on each entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_r       <= {PW{1'b0}};
         ms_r        <= {MW{1'b0}};
         blink_cnt_r <= {BW{1'b0}};
         celebrate_r <= 1'b0;
         blink_r     <= 1'b0;
      end else if (!in_cel_s || cel_entry_s) begin
         pre_r       <= {PW{1'b0}};
         ms_r        <= {MW{1'b0}};
         blink_cnt_r <= {BW{1'b0}};
         celebrate_r <= in_cel_s;
         blink_r     <= in_cel_s;
      end else begin
         celebrate_r <= 1'b1;
         if (pre_wrap_s) begin
            pre_r       <= {PW{1'b0}};
            ms_r        <= ms_r + MW'(1);
            blink_cnt_r <= blink_wrap_s ? {BW{1'b0}} : blink_cnt_r + BW'(1);
            if (blink_wrap_s) blink_r <= ~blink_r;
         end else begin
            pre_r <= pre_r + PW'(1);
         end
      end
   end

   assign high_score   = high_score_r;
   assign new_record   = new_record_r;
   assign celebrate    = celebrate_r;
   assign blink        = blink_r;
   assign games_played = games_played_r;

endmodule
